mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the 256x8 single-port `memory` block (combinational read, write on posedge when wr_en).
- Port A is the CPU datapath. Port B is the host/loader path, which writes program images and reads results.
- The block serializes accesses, drives memory adrs/data/wr_en, captures read data and returns a one-cycle ack per access.
- An optional lock lets B own memory exclusively during program load.

Parameters:
- RESET_FAVOR_A, 1, which requester wins the first simultaneous request after reset (1 = A, 0 = B).
- LOCK_EN, 1, 1 enables b_lock; 0 ties lock behaviour off (b_lock ignored).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_req  in  1  A request, held until a_ack
- a_we  in  1  A write(1)/read(0), stable while a_req
- a_adrs  in  8  A address, stable while a_req
- a_wdata  in  8  A write data, stable while a_req
- a_ack  out  1  one-cycle access-complete pulse
- a_rdata  out  8  A read data, valid when a_ack=1, held until next A read
- b_req, b_we, b_adrs[8], b_wdata[8], b_ack, b_rdata[8]  same as A
- b_lock  in  1  B exclusive-ownership request
- a_stalled  out  1  high while A is blocked by an active lock
- mem_adrs  out  8  to memory adrs
- mem_data  out  8  to memory data
- mem_wr_en  out  1  to memory wr_en
- mem_q  in  8  from memory q (combinational)

Behaviour:
- Reset (async, reset_n=0) values:
  - state=IDLE, last=B if RESET_FAVOR_A else A, locked=0.
  - a_ack=b_ack=0, a_rdata=b_rdata=0x00, a_stalled=0.
  - mem_wr_en=0 (forced combinationally while reset_n=0). No write can occur mid-reset.
- State machine: IDLE, SERVE_A, SERVE_B.
- Eligibility is computed every cycle from the current state:
  - elig_A = a_req & !(state==SERVE_A) & !locked
  - elig_B = b_req & !(state==SERVE_B)
  - The just-served requester is masked for exactly one cycle because its ack is not yet visible to it.
- Next state:
  - Both eligible: serve the one that is not `last`. `last` updates on entering SERVE_x.
  - Exactly one eligible: serve it.
  - Neither eligible: IDLE.
- SERVE_x cycle (combinational outputs):
  - mem_adrs = x_adrs, mem_data = x_wdata, mem_wr_en = x_we.
  - The write commits at the closing edge.
- Memory outputs in IDLE: mem_adrs=0x00, mem_data=0x00, mem_wr_en=0.
- Ack and read data:
  - x_ack is a register, <= (state==SERVE_x). It pulses in the cycle after SERVE_x.
  - x_rdata <= mem_q at the end of SERVE_x when x_we=0. It is unchanged on writes.
- Latency: req first seen high in IDLE at cycle 0 -> SERVE at cycle 1 -> ack at cycle 2.
- Throughput:
  - A single requester holding req high completes one access every 2 cycles.
  - Both requesting alternate A,B,A,B at one access per cycle, giving full memory utilization.
- Requester rules:
  - A requester drops req in its ack cycle, or keeps it high to request the next access with new operands applied in the ack cycle.
  - Operands must change only in or after the ack cycle.
- Lock (LOCK_EN=1):
  - locked sets at the end of any SERVE_B cycle where b_lock=1.
  - locked clears in the first cycle with b_lock=0, is not in SERVE_B, and has no b_ack pending.
  - While locked, A is ineligible and a_stalled = a_req.
  - An A access already in SERVE_A completes normally.
- Simultaneous events:
  - Read/write to the same address by A and B in consecutive cycles serializes in grant order.
  - A write followed by a read of the same address returns the new data.
- reset_n asserted mid-SERVE: the access is abandoned, with no ack and no write. Requesters reissue after reset.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE=2'd0, SERVE_A=2'd1, SERVE_B=2'd2)
  - requester ids (REQ_A=1'b0, REQ_B=1'b1)
  - ADRS_W=8, DATA_W=8
- One sub-module, arb_pick2: combinational two-way round-robin pick from (elig_A, elig_B, last), returning {valid, id}.

Test Plan:
- Memory ram[0x07]=0x03. A read 0x07 alone -> a_ack in cycle 2, a_rdata=0x03, mem_wr_en never high.
- A write 0x09<=0xA5, then A read 0x09 -> two acks 2 cycles apart, second a_rdata=0xA5.
- a_req and b_req rise in the same cycle after reset (RESET_FAVOR_A=1), both holding req with new operands each ack -> grant order A,B,A,B, an ack every cycle from cycle 2.
- B sets b_lock and writes 0x00<=0x81, 0x01<=0x07 while a_req held -> A not served, a_stalled=1. After b_lock drops, A read 0x01 returns 0x07.
- reset_n pulsed low during SERVE_B write of 0x10<=0xFF -> ram[0x10] unchanged, no b_ack, all outputs at reset values.
- A write 0x20<=0x11 in SERVE_A, then B read 0x20 in the next cycle -> b_rdata=0x11.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADRS_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } arb_state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } pick_t;

    typedef struct packed {
        logic [ADRS_W-1:0] adrs;
        logic [DATA_W-1:0] data;
        logic              wr_en;
    } mem_cmd_t;

endpackage

// File: rtl/arb_pick2.sv
// Two-way round-robin pick: on contention the requester that was not served last wins.
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic  elig_a,
    input  logic  elig_b,
    input  logic  last,
    output pick_t pick_c
);

    always_comb begin
        pick_c = '0;
        if (elig_a && elig_b) begin
            pick_c.valid = 1'b1;
            pick_c.id    = (last == REQ_A) ? REQ_B : REQ_A;
        end else if (elig_a) begin
            pick_c.valid = 1'b1;
            pick_c.id    = REQ_A;
        end else if (elig_b) begin
            pick_c.valid = 1'b1;
            pick_c.id    = REQ_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes CPU (A) and host (B) accesses onto a single-port memory, with an optional B lock.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit RESET_FAVOR_A = 1'b1,
    parameter bit LOCK_EN       = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADRS_W-1:0] a_adrs,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADRS_W-1:0] b_adrs,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              b_lock,
    output logic              a_stalled,
    output logic [ADRS_W-1:0] mem_adrs,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic LAST_RST = RESET_FAVOR_A ? REQ_B : REQ_A;

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              locked_q, locked_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              elig_a, elig_b;
    pick_t             pick;
    mem_cmd_t          mem_cmd;

    // The requester in SERVE is masked: its ack only appears next cycle.
    assign elig_a = a_req & (state_q != SERVE_A) & ~locked_q;
    assign elig_b = b_req & (state_q != SERVE_B);

    arb_pick2 u_pick (
        .elig_a (elig_a),
        .elig_b (elig_b),
        .last   (last_q),
        .pick_c (pick)
    );

    always_comb begin
        state_d   = IDLE;
        last_d    = last_q;
        locked_d  = locked_q;
        a_ack_d   = (state_q == SERVE_A);
        b_ack_d   = (state_q == SERVE_B);
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        mem_cmd   = '0;

        if (pick.valid) begin
            state_d = (pick.id == REQ_A) ? SERVE_A : SERVE_B;
            last_d  = pick.id;
        end

        case (state_q)
            SERVE_A: begin
                mem_cmd = '{adrs: a_adrs, data: a_wdata, wr_en: a_we};
                if (!a_we) a_rdata_d = mem_q;
            end
            SERVE_B: begin
                mem_cmd = '{adrs: b_adrs, data: b_wdata, wr_en: b_we};
                if (!b_we) b_rdata_d = mem_q;
            end
            default: ;
        endcase

        // Lock is taken by a served B access and held until B has fully drained.
        if (!LOCK_EN) begin
            locked_d = 1'b0;
        end else if ((state_q == SERVE_B) && b_lock) begin
            locked_d = 1'b1;
        end else if (!b_lock && (state_q != SERVE_B) && !b_ack_q) begin
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_q    <= LAST_RST;
            locked_q  <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            locked_q  <= locked_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign a_stalled = a_req & locked_q;
    assign mem_adrs  = mem_cmd.adrs;
    assign mem_data  = mem_cmd.data;
    // Gated by reset so an abandoned SERVE cannot commit a write.
    assign mem_wr_en = mem_cmd.wr_en & reset_n;

endmodule
